ls_align_unit: RTL
==================

// Module: ls_align_unit
// PURPOSE
//  Memory-stage load/store data aligner, registered and elastic. Loads: extracts the
//  addressed byte/half/word(/dword) from a full-width read word, then sign- or zero-extends
//  it. Stores: replicates store data across lanes and generates byte strobes. Sits between
//  the data-memory port and MEM/WB, behind a valid/ready handshake with a 2-entry skid buffer.
// PARAMETERS
//  XLEN      32  data-path width; legal values 32 or 64
//  NB        XLEN/8 (derived, localparam)  byte lanes
//  OFFW      $clog2(NB) (derived, localparam)  byte-offset width
// PORTS
//  clk          in   1     clock; everything updates on rising edge
//  rst          in   1     synchronous, active-high reset
//  flush        in   1     synchronous pipeline flush; discards all held entries
//  in_valid     in   1     request valid
//  in_ready     out  1     request accepted when in_valid & in_ready
//  in_is_store  in   1     1 = store, 0 = load
//  in_funct3    in   3     RISC-V funct3 of the access
//  in_addr_lo   in   OFFW  low address bits (byte offset within word)
//  in_rdata     in   XLEN  raw word read from memory (loads)
//  in_wdata     in   XLEN  rs2 value (stores)
//  out_valid    out  1     result valid
//  out_ready    in   1     consumer accepts when out_valid & out_ready
//  out_ldata    out  XLEN  aligned, extended load result
//  out_wdata    out  XLEN  lane-replicated store data
//  out_wstrb    out  NB    store byte enables (0 for loads)
//  out_err      out  1     illegal funct3 (and misaligned access when checked)
// BEHAVIOUR
//  - Reset or flush: both buffer entries empty; out_valid=0, in_ready=1, out_ldata/wdata/wstrb/err=0.
//  - Flush wins over a same-cycle in_valid: the request is dropped and is not accepted.
//  - Latency: 1 cycle. A request accepted in cycle N is presented in N+1.
//  - Ordering: results leave in strict acceptance order.
//  - Main register plus skid entry. in_ready = skid entry empty, driven from a flop.
//  - Transfers while out_valid=0 or out_ready=1 go to the main register.
//  - An accept during a stall fills the skid entry. in_ready drops the next cycle.
//  - Output is held stable while out_valid & !out_ready.
//  - Loads, funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
//    011 ld and 110 lwu are legal only when XLEN=64.
//  - Load: field = in_rdata >> (8*in_addr_lo), truncated to the access size.
//    Signed ops replicate the field MSB up to XLEN; unsigned ops zero-fill.
//  - Stores, funct3: 000 sb, 001 sh, 010 sw. 011 sd is legal only when XLEN=64.
//  - Store data: the low access-size bytes of in_wdata are replicated across all lanes.
//  - Store strobe: ((1<<size)-1) << in_addr_lo.
//  - Illegal funct3 (loads or stores): out_err=1, out_ldata=0, out_wstrb=0.
//  - Strobes never wrap. With alignment enforced, offset+size is always <= NB.
// CONFIGURATION
//  LS_MISALIGN_CHECK_EN defined:
//    in_addr_lo not a multiple of the access size -> out_err=1, out_wstrb=0, out_ldata=0.
//  LS_MISALIGN_CHECK_EN undefined:
//    Offset bits below the access size are cleared (access is forced to natural alignment).
//    out_err then flags illegal funct3 only.
// STRUCTURE
//  - Package ls_pkg: funct3 load/store enums; size_bytes(funct3) function; sext/zext helpers.
//  - Sub-module ls_skid_buf #(W): generic 2-entry valid/ready skid buffer.
//    This block instantiates it with W = 2*XLEN+NB+1.
//  - Align/extend logic is combinational, placed in front of the skid buffer.
// TESTING
//  1 XLEN=32, lb, off=3, rdata=0x80FF_1234 -> ldata=0xFFFF_FF80, err=0, one cycle later.
//  2 lhu, off=2, rdata=0x80FF_1234 -> ldata=0x0000_80FF; lh at same address -> 0xFFFF_80FF.
//  3 sb, off=1, wdata=0x0000_00AB -> out_wdata=0xABAB_ABAB, out_wstrb=4'b0010.
//  4 out_ready=0 for 3 cycles, in_valid=1 with 3 distinct lw:
//    2 accepted, in_ready=0 from cycle 2; on release, outputs appear in order, nothing lost.
//  5 lw, off=2:
//    with LS_MISALIGN_CHECK_EN -> err=1, ldata=0.
//    without -> ldata=rdata (offset 0), err=0.
//  6 flush while both entries full -> next cycle out_valid=0, in_ready=1.
//    funct3=011 at XLEN=32 -> err=1.

Source files
------------

// File: rtl/ls_pkg.sv
// ls_pkg: shared definitions for the load/store aligner.
//  - ld_op_e / st_op_e : RISC-V funct3 encodings for loads and stores
//  - size_bytes()      : access size in bytes for a funct3
//  - sext() / zext()   : sign/zero extension of the low nbytes of a 64-bit value
package ls_pkg;

  typedef enum logic [2:0] {
    LD_LB  = 3'b000,
    LD_LH  = 3'b001,
    LD_LW  = 3'b010,
    LD_LD  = 3'b011,
    LD_LBU = 3'b100,
    LD_LHU = 3'b101,
    LD_LWU = 3'b110
  } ld_op_e;

  typedef enum logic [2:0] {
    ST_SB = 3'b000,
    ST_SH = 3'b001,
    ST_SW = 3'b010,
    ST_SD = 3'b011
  } st_op_e;

  // Size is encoded in funct3[1:0] for both loads and stores; illegal
  // encodings still get a size, and legality is checked separately.
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_bytes = 4'd1;
      2'b01:   size_bytes = 4'd2;
      2'b10:   size_bytes = 4'd4;
      default: size_bytes = 4'd8;
    endcase
  endfunction

  function automatic logic [63:0] zext(input logic [63:0] v, input logic [3:0] nbytes);
    case (nbytes)
      4'd1:    zext = {56'd0, v[7:0]};
      4'd2:    zext = {48'd0, v[15:0]};
      4'd4:    zext = {32'd0, v[31:0]};
      default: zext = v;
    endcase
  endfunction

  function automatic logic [63:0] sext(input logic [63:0] v, input logic [3:0] nbytes);
    case (nbytes)
      4'd1:    sext = {{56{v[7]}}, v[7:0]};
      4'd2:    sext = {{48{v[15]}}, v[15:0]};
      4'd4:    sext = {{32{v[31]}}, v[31:0]};
      default: sext = v;
    endcase
  endfunction

endpackage

// File: rtl/ls_skid_buf.sv
// ls_skid_buf: generic 2-entry valid/ready skid buffer, 1-cycle latency.
//  clk, rst        clock, synchronous active-high reset
//  flush           discard both entries; a same-cycle request is dropped
//  in_valid/ready  upstream handshake; in_ready is the inverted skid-valid flop
//  in_data [W]     upstream payload
//  out_valid/ready downstream handshake; out_data held stable while stalled
//  out_data [W]    downstream payload (main register)
module ls_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_q, main_valid_d;
  logic [W-1:0] main_data_q,  main_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q,  skid_data_d;
  logic         accept;

  // The skid entry can only fill when main is stalled, so an empty skid
  // always guarantees room for one more request.
  assign in_ready  = ~skid_valid_q;
  assign accept    = in_valid & ~skid_valid_q & ~flush;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      main_valid_d = 1'b0;
      main_data_d  = '0;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
    end else if (!main_valid_q || out_ready) begin
      // Main is free or draining: the older skid entry has priority; when it is
      // full in_ready is low, so no new request competes with it.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_data_d = in_data;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/ls_align_unit.sv
// ls_align_unit: memory-stage load/store aligner behind a 2-entry skid buffer.
//  Loads : extract byte/half/word(/dword) at in_addr_lo from in_rdata, sign/zero extend.
//  Stores: replicate low access bytes of in_wdata across lanes, build byte strobes.
//  Ports : clk, rst (sync, active-high), flush, in_valid/in_ready, in_is_store,
//          in_funct3, in_addr_lo, in_rdata, in_wdata, out_valid/out_ready,
//          out_ldata, out_wdata, out_wstrb, out_err.
//  Config: LS_MISALIGN_CHECK_EN defined -> misaligned accesses raise out_err;
//          undefined -> offset bits below the access size are cleared.
module ls_align_unit
  import ls_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_is_store,
  input  logic [2:0]                in_funct3,
  input  logic [$clog2(XLEN/8)-1:0] in_addr_lo,
  input  logic [XLEN-1:0]           in_rdata,
  input  logic [XLEN-1:0]           in_wdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_ldata,
  output logic [XLEN-1:0]           out_wdata,
  output logic [XLEN/8-1:0]         out_wstrb,
  output logic                      out_err
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int W    = 2 * XLEN + NB + 1;
  localparam bit IS64 = (XLEN == 64);

  logic [3:0]      size;
  logic [OFFW-1:0] size_mask;
  logic [OFFW-1:0] off;
  logic            legal;
  logic            err;
  logic [XLEN-1:0] ldata;
  logic [XLEN-1:0] wdata;
  logic [NB-1:0]   wstrb;
  logic [63:0]     field;
  logic [W-1:0]    in_pkt;
  logic [W-1:0]    out_pkt;

  assign size      = size_bytes(in_funct3);
  assign size_mask = OFFW'(size - 4'd1);

  always_comb begin
    legal = 1'b0;
    if (in_is_store) begin
      case (st_op_e'(in_funct3))
        ST_SB, ST_SH, ST_SW: legal = 1'b1;
        ST_SD:               legal = IS64;
        default:             legal = 1'b0;
      endcase
    end else begin
      case (ld_op_e'(in_funct3))
        LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: legal = 1'b1;
        LD_LD, LD_LWU:                       legal = IS64;
        default:                             legal = 1'b0;
      endcase
    end
  end

`ifdef LS_MISALIGN_CHECK_EN
  assign off = in_addr_lo;
  assign err = ~legal | ((in_addr_lo & size_mask) != '0);
`else
  // Force natural alignment by dropping offset bits below the access size.
  assign off = in_addr_lo & ~size_mask;
  assign err = ~legal;
`endif

  assign field = 64'(in_rdata) >> {off, 3'b000};

  always_comb begin
    ldata = '0;
    wdata = '0;
    wstrb = '0;
    if (in_is_store) begin
      for (int i = 0; i < NB; i++) begin
        wdata[8*i +: 8] = in_wdata[8*(i % int'(size)) +: 8];
      end
      if (!err) wstrb = NB'(((16'd1 << size) - 16'd1) << off);
    end else if (!err) begin
      ldata = in_funct3[2] ? XLEN'(zext(field, size)) : XLEN'(sext(field, size));
    end
  end

  assign in_pkt = {err, wstrb, wdata, ldata};

  ls_skid_buf #(.W(W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pkt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pkt)
  );

  assign {out_err, out_wstrb, out_wdata, out_ldata} = out_pkt;

endmodule
